// File: rtl/add_pipe_n.sv
// add_pipe_n: pipelined unsigned adder whose carry chain is cut into
// STAGES registered segments. Each transaction carries its own mode bit:
// exact (A + B + cin) or approximate, where the low APPROX_LSB bits are a
// plain OR and only the top bit of the low part generates a carry.
// The pipeline is fully elastic: a stage loads whenever the stage after it
// can move or it is itself empty, so bubbles collapse and a full pipeline
// keeps streaming at one result per cycle while out_ready is high.
module add_pipe_n #(
    parameter int WIDTH      = 8,
    parameter int STAGES     = 2,
    parameter int APPROX_LSB = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             approx_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   O
);

    // Bits resolved per stage; trailing segments may be short or empty.
    localparam int SEG   = (WIDTH + STAGES - 1) / STAGES;
    // Operand and mode registers are only needed ahead of the last stage.
    localparam int NPIPE = (STAGES > 1) ? STAGES - 1 : 1;

    logic [STAGES-1:0]            vld_r;
    logic [STAGES-1:0][WIDTH-1:0] sum_r;
    logic [STAGES-1:0]            carry_r;
    logic [NPIPE-1:0][WIDTH-1:0]  a_r;
    logic [NPIPE-1:0][WIDTH-1:0]  b_r;
    logic [NPIPE-1:0]             mode_r;
    logic [STAGES-1:0]            adv_s;
    logic                         mode_in_s;

    // With no approximable low part every transaction is exact.
    assign mode_in_s = (APPROX_LSB > 0) ? approx_en : 1'b0;

    // Advance chain: a stage may load if the next one moves or it is empty.
    always_comb begin
        logic run_s;
        adv_s = '0;
        run_s = out_ready | ~vld_r[STAGES-1];
        adv_s[STAGES-1] = run_s;
        for (int k = STAGES - 2; k >= 0; k--) begin
            run_s    = run_s | ~vld_r[k];
            adv_s[k] = run_s;
        end
    end

    assign in_ready  = adv_s[0];
    assign out_valid = vld_r[STAGES-1];
    assign O         = {carry_r[STAGES-1], sum_r[STAGES-1]};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = (k * SEG < WIDTH) ? k * SEG : WIDTH;
        localparam int HI = ((k + 1) * SEG < WIDTH) ? (k + 1) * SEG : WIDTH;

        logic [WIDTH-1:0] a_s;
        logic [WIDTH-1:0] b_s;
        logic [WIDTH-1:0] sum_in_s;
        logic [WIDTH-1:0] sum_nx_s;
        logic             carry_in_s;
        logic             carry_nx_s;
        logic             mode_s;
        logic             vld_in_s;

        if (k == 0) begin : g_head
            assign a_s        = A;
            assign b_s        = B;
            assign sum_in_s   = '0;
            // Approximate transactions ignore the external carry-in.
            assign carry_in_s = cin & ~mode_in_s;
            assign mode_s     = mode_in_s;
            assign vld_in_s   = in_valid;
        end else begin : g_body
            assign a_s        = a_r[k-1];
            assign b_s        = b_r[k-1];
            assign sum_in_s   = sum_r[k-1];
            assign carry_in_s = carry_r[k-1];
            assign mode_s     = mode_r[k-1];
            assign vld_in_s   = vld_r[k-1];
        end

        // Resolve this stage's segment; bits outside it pass through.
        always_comb begin
            logic carry_s;
            sum_nx_s = sum_in_s;
            carry_s  = carry_in_s;
            for (int i = 0; i < WIDTH; i++) begin
                if ((i >= LO) && (i < HI)) begin
                    if (mode_s && (i < APPROX_LSB)) begin
                        sum_nx_s[i] = a_s[i] | b_s[i];
                        // Only the top bit of the OR part feeds the upper adder.
                        if (i == APPROX_LSB - 1) begin
                            carry_s = a_s[i] & b_s[i];
                        end else begin
                            carry_s = 1'b0;
                        end
                    end else begin
                        sum_nx_s[i] = a_s[i] ^ b_s[i] ^ carry_s;
                        carry_s     = (a_s[i] & b_s[i]) | (carry_s & (a_s[i] ^ b_s[i]));
                    end
                end else begin
                    sum_nx_s[i] = sum_in_s[i];
                end
            end
            carry_nx_s = carry_s;
        end

        // Stage valid, partial sum and carry: load on advance, else hold.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_r[k]   <= 1'b0;
                sum_r[k]   <= '0;
                carry_r[k] <= 1'b0;
            end else if (adv_s[k]) begin
                vld_r[k] <= vld_in_s;
                if (vld_in_s) begin
                    sum_r[k]   <= sum_nx_s;
                    carry_r[k] <= carry_nx_s;
                end
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            // Operands and mode travel with the transaction to later segments.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_r[k]    <= '0;
                    b_r[k]    <= '0;
                    mode_r[k] <= 1'b0;
                end else if (adv_s[k] && vld_in_s) begin
                    a_r[k]    <= a_s;
                    b_r[k]    <= b_s;
                    mode_r[k] <= mode_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_add_pipe_n.sv
// Directed bench for add_pipe_n: an 8-bit/2-stage instance for the
// hand-computed vectors and a 16-bit/4-stage instance for a longer
// stream checked against a reference model.
module tb_add_pipe_n;

    logic        clk;
    logic        rst_n;

    logic        in_valid, in_ready, cin, approx_en, out_valid, out_ready;
    logic [7:0]  a, b;
    logic [8:0]  o;

    logic        in_valid16, in_ready16, cin16, approx16, out_valid16, out_ready16;
    logic [15:0] a16, b16;
    logic [16:0] o16;

    int checks;
    int failures;

    add_pipe_n #(.WIDTH(8), .STAGES(2), .APPROX_LSB(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .cin(cin), .approx_en(approx_en),
        .out_valid(out_valid), .out_ready(out_ready), .O(o)
    );

    add_pipe_n #(.WIDTH(16), .STAGES(4), .APPROX_LSB(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .A(a16), .B(b16), .cin(cin16), .approx_en(approx16),
        .out_valid(out_valid16), .out_ready(out_ready16), .O(o16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: exact sum, or OR low nibble with top-bit carry into upper sum.
    function automatic logic [16:0] ref_add16(input logic [15:0] x, input logic [15:0] y,
                                              input logic c, input logic m);
        logic [16:0] hi;
        logic [16:0] r;
        if (m) begin
            hi = 17'(x[15:4]) + 17'(y[15:4]) + 17'(x[3] & y[3]);
            r  = (hi << 4) | 17'(x[3:0] | y[3:0]);
        end else begin
            r = 17'(x) + 17'(y) + 17'(c);
        end
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0]  bp_exp [4];
        logic [16:0] sb [$];
        logic [16:0] expv;
        int ii, oi, acc, emitted;

        checks = 0; failures = 0;
        rst_n = 1'b0;
        in_valid = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0; approx_en = 1'b0; out_ready = 1'b1;
        in_valid16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000; cin16 = 1'b0; approx16 = 1'b0; out_ready16 = 1'b1;
        repeat (2) tick();
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_o", 32'(o), 32'd0);
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_out_valid16", 32'(out_valid16), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Exact max with carry-in, latency 2.
        a = 8'hFF; b = 8'hFF; cin = 1'b1; approx_en = 1'b0; in_valid = 1'b1;
        #1;
        check_val("max_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check_val("max_lat_early", 32'(out_valid), 32'd0);
        tick();
        check_val("max_valid", 32'(out_valid), 32'd1);
        check_val("max_o", 32'(o), 32'h1FF);
        tick();
        check_val("max_done", 32'(out_valid), 32'd0);

        // Segment-boundary carry, exact then approximate, back-to-back.
        a = 8'h0F; b = 8'h01; cin = 1'b0; approx_en = 1'b0; in_valid = 1'b1;
        tick();
        approx_en = 1'b1;
        tick();
        in_valid = 1'b0; approx_en = 1'b0;
        check_val("seg_exact_valid", 32'(out_valid), 32'd1);
        check_val("seg_exact_o", 32'(o), 32'h010);
        tick();
        check_val("seg_approx_valid", 32'(out_valid), 32'd1);
        check_val("seg_approx_o", 32'(o), 32'h00F);
        tick();
        check_val("seg_done", 32'(out_valid), 32'd0);

        // Backpressure: fill with out_ready low, then drain in order.
        out_ready = 1'b0;
        a = 8'd1; b = 8'd2; in_valid = 1'b1;
        #1;
        check_val("bp_ready0", 32'(in_ready), 32'd1);
        tick();
        a = 8'd3; b = 8'd4;
        #1;
        check_val("bp_ready1", 32'(in_ready), 32'd1);
        tick();
        a = 8'd5; b = 8'd6;
        #1;
        check_val("bp_full_ready", 32'(in_ready), 32'd0);
        for (int n = 0; n < 5; n++) begin
            tick();
            check_val("bp_hold_o", 32'(o), 32'h003);
            check_val("bp_hold_valid", 32'(out_valid), 32'd1);
            check_val("bp_hold_ready", 32'(in_ready), 32'd0);
        end
        bp_exp[0] = 9'd3; bp_exp[1] = 9'd7; bp_exp[2] = 9'd11; bp_exp[3] = 9'd15;
        out_ready = 1'b1;
        ii = 2; oi = 0;
        for (int cyc = 0; cyc < 12 && oi < 4; cyc++) begin
            #1;
            if (out_valid) begin
                check_val("bp_out", 32'(o), 32'(bp_exp[oi]));
                oi++;
            end
            if (in_valid && in_ready) ii++;
            tick();
            if (ii < 4) begin
                a = 8'(2 * ii + 1); b = 8'(2 * ii + 2); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
        check_val("bp_count", 32'(oi), 32'd4);
        check_val("bp_drained", 32'(out_valid), 32'd0);

        // Approximate carry rule; cin must be ignored.
        a = 8'h18; b = 8'h08; cin = 1'b1; approx_en = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; cin = 1'b0; approx_en = 1'b0;
        tick();
        check_val("apx_valid", 32'(out_valid), 32'd1);
        check_val("apx_o", 32'(o), 32'h028);
        tick();

        // Reset with two transactions in flight.
        out_ready = 1'b0;
        a = 8'h33; b = 8'h44; in_valid = 1'b1;
        tick();
        a = 8'h55; b = 8'h11;
        tick();
        in_valid = 1'b0;
        check_val("mrst_pre_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("mrst_valid", 32'(out_valid), 32'd0);
        check_val("mrst_o", 32'(o), 32'd0);
        check_val("mrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        check_val("mrst_no_stale", 32'(out_valid), 32'd0);
        a = 8'h10; b = 8'h20; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_val("mrst_lat_early", 32'(out_valid), 32'd0);
        tick();
        check_val("mrst_new_valid", 32'(out_valid), 32'd1);
        check_val("mrst_new_o", 32'(o), 32'h030);
        tick();
        check_val("mrst_done", 32'(out_valid), 32'd0);

        // 16-bit, 4-stage latency with an unstalled consumer.
        a16 = 16'h1234; b16 = 16'hFEDC; cin16 = 1'b1; approx16 = 1'b0; in_valid16 = 1'b1;
        tick();
        in_valid16 = 1'b0;
        for (int n = 0; n < 3; n++) begin
            check_val("w16_lat_early", 32'(out_valid16), 32'd0);
            tick();
        end
        check_val("w16_valid", 32'(out_valid16), 32'd1);
        check_val("w16_o", 32'(o16), 32'h11111);
        tick();

        // 16-bit stream with random operands, mode, valid and backpressure.
        acc = 0; emitted = 0;
        for (int cyc = 0; cyc < 20000 && emitted < 2000; cyc++) begin
            in_valid16  = (acc < 2000) ? ($urandom_range(0, 3) != 0) : 1'b0;
            a16         = 16'($urandom);
            b16         = 16'($urandom);
            cin16       = 1'($urandom_range(0, 1));
            approx16    = 1'($urandom_range(0, 1));
            out_ready16 = ($urandom_range(0, 3) != 0);
            #1;
            if (in_valid16 && in_ready16) begin
                sb.push_back(ref_add16(a16, b16, cin16, approx16));
                acc++;
            end
            if (out_valid16 && out_ready16) begin
                if (sb.size() > 0) expv = sb.pop_front();
                else expv = 'x;
                check_val("r16_o", 32'(o16), 32'(expv));
                emitted++;
            end
            tick();
        end
        check_val("r16_count", 32'(emitted), 32'd2000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
